dot_prod_unit: RTL and testbench
================================

# dot_prod_unit

Pipelined reduction and accumulation stage sitting directly downstream of the instruction decoder and the PE lane array. It consumes the per-lane multiply results from the PEs together with the decoder's `dot_prod_en` and `shift` controls. It reduces the lane products through a registered adder tree and accumulates partial sums across instructions. On a shift op it pushes the finished dot product into a lane-wide result vector, which the write-back mux selects when `r_select = 1`.

## Interface
- `LANES`, 4: PE lanes; power of two, ≥ 2.
- `DATA_WIDTH`, 32: lane and result width.
- `ADDR_WIDTH`, 10: result BRAM address width.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `half_clk`  in  1  instruction strobe; an instruction is sampled only on cycles where this is 1.
- `dot_prod_en`  in  1  current instruction is a dot-product op.
- `shift`  in  1  1 = finish and shift the result out, 0 = accumulate only.
- `r_addr`  in  ADDR_WIDTH  destination address of the current instruction.
- `prod`  in  LANES*DATA_WIDTH  PE multiply outputs; lane i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `dp_vec`  out  LANES*DATA_WIDTH  result vector; lane 0 holds the newest result.
- `dp_valid`  out  1  one-cycle pulse when `dp_vec` has just been updated by a shift op.
- `dp_addr`  out  ADDR_WIDTH  `r_addr` of the shift op that produced the pulse.
- `busy`  out  1  any pipeline stage holds a valid op.

## Operation
- **Accept:** an op is accepted on a rising edge where `rstn=1`, `half_clk=1` and `dot_prod_en=1`.
  - On accept, `prod`, `shift` and `r_addr` are captured into the pipeline.
  - `dot_prod_en` while `half_clk=0` is ignored.
- **Adder tree:** S = log2(LANES) registered stages.
  - Stage k adds adjacent pairs of stage k-1.
  - Each stage carries a valid bit, the `shift` flag and the address.
- **Final stage:** `sum = acc + tree_out`.
  - If the op is accumulate: `acc <= sum`.
  - If the op is shift:
    - `dp_vec <= {dp_vec[lanes LANES-2..0], sum}` (lane 0 ← sum, lane i ← old lane i-1, old top lane dropped);
    - `acc <= 0`;
    - `dp_valid <= 1`;
    - `dp_addr <=` the op's address.
- **Arithmetic:** two's complement, DATA_WIDTH bits at every adder. Default behaviour wraps modulo 2^DATA_WIDTH (see Configuration).
- **Ordering:** ops stay strictly in order. Back-to-back accepts every second cycle (the decoder cadence) need no stall. Accepts on consecutive cycles are also legal and are fully pipelined.
- **Back-to-back shift then accumulate:** `acc` clears on the shift, and the following accumulate starts from 0 with no bubble.
- **Reset (including mid-operation):** all of the following go to 0; in-flight ops are discarded and no `dp_valid` is produced for them:
  - pipeline valids;
  - `acc`;
  - `dp_vec`;
  - `dp_valid`;
  - `dp_addr`;
  - `busy`.
- **Reset values:** every output is 0.

## Timing
- An op accepted at edge E0 has its lane sums at the stage-1 registers after E0, and the tree result after edge E(S-1).
- The final stage updates at E(S): `acc`, `dp_vec` and `dp_valid` change at E(S).
- Latency from the accept edge is S+1 edges: 3 for LANES=4 and 4 for LANES=8.
- `dp_valid` is high for exactly one cycle per shift op. Accumulate ops never assert it.
- `busy` is the registered OR of all stage valids. It is high from the edge after accept until the final stage has consumed the op.
- The downstream write (`write_en` with `r_select=1`) must be aligned to `dp_valid`/`dp_addr`, not to the decoder cycle.

## Configuration
- `DOT_SATURATE_EN`
  - **Defined:** every tree adder and the accumulator use signed saturation. A result above 2^(DATA_WIDTH-1)-1 clamps to that maximum; a result below -2^(DATA_WIDTH-1) clamps to that minimum.
  - **Undefined:** all adds wrap modulo 2^DATA_WIDTH.
  - Latency is identical in both builds.

## Test plan
- **Accumulate then shift:**
  - Stimulus: LANES=4; accumulate `prod`=1,2,3,4; then shift `prod`=5,6,7,8 with `r_addr`=0x05.
  - Response: `acc` = 10 after the first op; single `dp_valid` 3 edges after the shift accept; `dp_vec` lane0 = 36; `dp_addr` = 0x05; `acc` = 0.
- **Vector shifting:**
  - Stimulus: three shift ops with lane products summing to 10, 20, 30.
  - Response: `dp_vec` lanes 0..2 = 30, 20, 10; lane 3 = 0.
- **half_clk gating:**
  - Stimulus: `dot_prod_en=1` held with `half_clk=0` for 4 cycles.
  - Response: no accept, `busy` = 0, `acc` unchanged.
- **Reset mid-flight:**
  - Stimulus: shift op accepted, `rstn`=0 at the next edge.
  - Response: no `dp_valid` ever; all outputs 0; the next op starts from `acc`=0.
- **Overflow:**
  - Stimulus: all lanes = 0x7FFFFFFF, shift.
  - Response: without `DOT_SATURATE_EN`, lane0 = 0xFFFFFFFC; with it, lane0 = 0x7FFFFFFF.
- **Full-rate pipelining:**
  - Stimulus: accepts on 4 consecutive cycles (shift, acc, acc, shift).
  - Response: two `dp_valid` pulses 3 cycles apart, with correct sums and addresses.

Source files
------------

// File: rtl/dot_prod_unit.sv
// dot_prod_unit
// Registered adder-tree reduction of the PE lane products followed by an
// accumulator. A shift op pushes the finished dot product into lane 0 of a
// lane-wide result vector and pulses dp_valid together with its address.
// Optional build macro: DOT_SATURATE_EN -- when defined, every tree adder and
// the accumulator clamp to the signed DATA_WIDTH range instead of wrapping.
module dot_prod_unit #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         half_clk,
    input  logic                         dot_prod_en,
    input  logic                         shift,
    input  logic [ADDR_WIDTH-1:0]        r_addr,
    input  logic [LANES*DATA_WIDTH-1:0]  prod,
    output logic [LANES*DATA_WIDTH-1:0]  dp_vec,
    output logic                         dp_valid,
    output logic [ADDR_WIDTH-1:0]        dp_addr,
    output logic                         busy
);

    localparam int STAGES = $clog2(LANES);
    // Tree nodes are stored flat: stage 1 first, root last.
    localparam int NODES  = LANES - 1;
    localparam int ROOT   = LANES - 2;

    // First flat index of the nodes belonging to tree stage k.
    function automatic int node_off(input int k);
        return LANES - (LANES >> (k - 1));
    endfunction

    // Single adder used everywhere so the tree and the accumulator share one
    // overflow behaviour.
    function automatic logic [DATA_WIDTH-1:0] add_op(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
`ifdef DOT_SATURATE_EN
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
            return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return s[DATA_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    logic                   accept;
    logic [DATA_WIDTH-1:0]  node_next [0:NODES-1];
    logic [DATA_WIDTH-1:0]  node_reg  [0:NODES-1];
    logic [STAGES:1]        vld_next, vld_reg;
    logic [STAGES:1]        shf_next, shf_reg;
    logic [ADDR_WIDTH-1:0]  adr_next [1:STAGES];
    logic [ADDR_WIDTH-1:0]  adr_reg  [1:STAGES];
    logic                   busy_reg;

    logic [DATA_WIDTH-1:0]        acc_reg;
    logic [DATA_WIDTH-1:0]        final_sum;
    logic [LANES*DATA_WIDTH-1:0]  dp_vec_reg;
    logic                         dp_valid_reg;
    logic [ADDR_WIDTH-1:0]        dp_addr_reg;

    assign accept = half_clk & dot_prod_en;

    genvar gi, gj;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_stage
            for (gj = 0; gj < (LANES >> gi); gj++) begin : g_node
                if (gi == 1) begin : g_leaf
                    assign node_next[gj] =
                        add_op(prod[(2*gj)*DATA_WIDTH +: DATA_WIDTH],
                               prod[(2*gj+1)*DATA_WIDTH +: DATA_WIDTH]);
                end else begin : g_inner
                    assign node_next[node_off(gi)+gj] =
                        add_op(node_reg[node_off(gi-1)+2*gj],
                               node_reg[node_off(gi-1)+2*gj+1]);
                end
            end
        end

        // Control sideband travels alongside the data, one stage per edge.
        for (gi = 2; gi <= STAGES; gi++) begin : g_ctrl
            assign vld_next[gi] = vld_reg[gi-1];
            assign shf_next[gi] = shf_reg[gi-1];
            assign adr_next[gi] = adr_reg[gi-1];
        end
    endgenerate

    assign vld_next[1] = accept;
    assign shf_next[1] = shift;
    assign adr_next[1] = r_addr;

    // Tree data registers; contents are only meaningful where the valid is set.
    always_ff @(posedge clk) begin
        node_reg <= node_next;
        shf_reg  <= shf_next;
        adr_reg  <= adr_next;
    end

    // Stage valids and busy; reset drops every in-flight op.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_reg  <= '0;
            busy_reg <= 1'b0;
        end else begin
            vld_reg  <= vld_next;
            busy_reg <= |vld_next;
        end
    end

    assign final_sum = add_op(acc_reg, node_reg[ROOT]);

    // Final stage: accumulate, or finish and shift the result into lane 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_reg      <= '0;
            dp_vec_reg   <= '0;
            dp_valid_reg <= 1'b0;
            dp_addr_reg  <= '0;
        end else begin
            dp_valid_reg <= 1'b0;
            if (vld_reg[STAGES]) begin
                if (shf_reg[STAGES]) begin
                    dp_vec_reg   <= {dp_vec_reg[(LANES-1)*DATA_WIDTH-1:0], final_sum};
                    acc_reg      <= '0;
                    dp_valid_reg <= 1'b1;
                    dp_addr_reg  <= adr_reg[STAGES];
                end else begin
                    acc_reg <= final_sum;
                end
            end
        end
    end

    assign dp_vec   = dp_vec_reg;
    assign dp_valid = dp_valid_reg;
    assign dp_addr  = dp_addr_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_dot_prod_unit.sv
// Directed, table-driven bench for dot_prod_unit (LANES=4, DATA_WIDTH=32).
module tb_dot_prod_unit;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int AW    = 10;

`ifdef DOT_SATURATE_EN
    localparam logic [DW-1:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [DW-1:0] OVF_EXP = 32'hFFFF_FFFC;
`endif

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  half_clk;
    logic                  dot_prod_en;
    logic                  shift;
    logic [AW-1:0]         r_addr;
    logic [LANES*DW-1:0]   prod;
    logic [LANES*DW-1:0]   dp_vec;
    logic                  dp_valid;
    logic [AW-1:0]         dp_addr;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_prod_unit #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .half_clk(half_clk), .dot_prod_en(dot_prod_en),
        .shift(shift), .r_addr(r_addr), .prod(prod), .dp_vec(dp_vec),
        .dp_valid(dp_valid), .dp_addr(dp_addr), .busy(busy)
    );

    typedef struct packed {
        logic           sh;
        logic [AW-1:0]  addr;
        logic [127:0]   p;
        logic           v;
        logic [127:0]   vec;
        logic [AW-1:0]  eaddr;
    } vec_t;

    vec_t tbl [9];

    // Lane 0 is the first argument (lowest bits).
    function automatic logic [127:0] mk(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one accept edge.
    task automatic drive(input logic sh, input logic [AW-1:0] addr, input logic [127:0] p);
        half_clk    = 1'b1;
        dot_prod_en = 1'b1;
        shift       = sh;
        r_addr      = addr;
        prod        = p;
        step();
        half_clk    = 1'b0;
        dot_prod_en = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic v, input logic [127:0] vec,
                              input logic [AW-1:0] addr);
        chk({tag, " dp_valid"}, 128'(dp_valid), 128'(v));
        chk({tag, " dp_vec"},   dp_vec,         vec);
        chk({tag, " dp_addr"},  128'(dp_addr),  128'(addr));
    endtask

    initial begin
        vec_t   fr [4];
        logic [127:0] v_exp;

        tbl[0] = '{1'b1, 10'h011, mk(1,2,3,4),    1'b1, mk(10,0,0,0),      10'h011};
        tbl[1] = '{1'b1, 10'h012, mk(2,4,6,8),    1'b1, mk(20,10,0,0),     10'h012};
        tbl[2] = '{1'b1, 10'h013, mk(3,6,9,12),   1'b1, mk(30,20,10,0),    10'h013};
        tbl[3] = '{1'b0, 10'h001, mk(1,2,3,4),    1'b0, mk(30,20,10,0),    10'h013};
        tbl[4] = '{1'b1, 10'h005, mk(5,6,7,8),    1'b1, mk(36,30,20,10),   10'h005};
        tbl[5] = '{1'b1, 10'h3FF, mk(-1,-2,-3,-4),1'b1, mk(-10,36,30,20),  10'h3FF};
        tbl[6] = '{1'b0, 10'h000, mk(100,0,0,0),  1'b0, mk(-10,36,30,20),  10'h3FF};
        tbl[7] = '{1'b0, 10'h000, mk(-50,0,0,0),  1'b0, mk(-10,36,30,20),  10'h3FF};
        tbl[8] = '{1'b1, 10'h02A, mk(0,0,0,1),    1'b1, mk(51,-10,36,30),  10'h02A};

        rstn = 1'b0; half_clk = 1'b0; dot_prod_en = 1'b0; shift = 1'b0;
        r_addr = '0; prod = '0;
        step();
        step();
        chk_result("reset", 1'b0, '0, '0);
        chk("reset busy", 128'(busy), 128'd0);
        rstn = 1'b1;

        // Table: one op at a time, result checked on the third edge.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].sh, tbl[i].addr, tbl[i].p);
            step();
            step();
            chk_result($sformatf("op%0d", i), tbl[i].v, tbl[i].vec, tbl[i].eaddr);
            $display("op %0d shift=%0d addr=%h valid=%0d lane0=%h", i, tbl[i].sh,
                     tbl[i].addr, dp_valid, dp_vec[31:0]);
            step();
            chk($sformatf("op%0d pulse end", i), 128'(dp_valid), 128'd0);
        end

        // half_clk gating: held dot_prod_en with half_clk low must not accept.
        drive(1'b0, 10'h000, mk(5,0,0,0));
        step(); step(); step();
        half_clk = 1'b0; dot_prod_en = 1'b1; shift = 1'b1; r_addr = 10'h009;
        prod = mk(100,100,100,100);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("gate%0d busy", i),  128'(busy),     128'd0);
            chk($sformatf("gate%0d valid", i), 128'(dp_valid), 128'd0);
        end
        dot_prod_en = 1'b0;
        step(); step(); step();
        chk("gate late valid", 128'(dp_valid), 128'd0);
        drive(1'b1, 10'h007, mk(0,0,0,0));
        step(); step();
        chk_result("gate acc kept", 1'b1, mk(5,51,-10,36), 10'h007);
        $display("gating: lane0=%h addr=%h", dp_vec[31:0], dp_addr);
        step();

        // Reset mid-flight: in-flight shift and a non-zero acc are discarded.
        drive(1'b0, 10'h000, mk(7,0,0,0));
        step(); step(); step();
        drive(1'b1, 10'h055, mk(1,1,1,1));
        rstn = 1'b0;
        step();
        chk_result("midrst", 1'b0, '0, '0);
        chk("midrst busy", 128'(busy), 128'd0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("midrst quiet%0d", i), 128'(dp_valid), 128'd0);
        end
        drive(1'b1, 10'h0AA, mk(2,0,0,0));
        step(); step();
        chk_result("after reset", 1'b1, mk(2,0,0,0), 10'h0AA);
        $display("after reset: lane0=%h addr=%h", dp_vec[31:0], dp_addr);
        step();

        // Overflow on every adder.
        drive(1'b1, 10'h00B, {4{32'h7FFF_FFFF}});
        step(); step();
        v_exp = {32'd0, 32'd0, 32'd2, OVF_EXP};
        chk_result("overflow", 1'b1, v_exp, 10'h00B);
        $display("overflow: lane0=%h", dp_vec[31:0]);
        step();

        // Full-rate: shift, acc, acc, shift on consecutive edges.
        fr[0] = '{1'b1, 10'h021, mk(1,1,1,1),  1'b0, '0, '0};
        fr[1] = '{1'b0, 10'h022, mk(10,0,0,0), 1'b0, '0, '0};
        fr[2] = '{1'b0, 10'h023, mk(0,20,0,0), 1'b0, '0, '0};
        fr[3] = '{1'b1, 10'h024, mk(0,0,0,3),  1'b0, '0, '0};
        for (int e = 0; e < 7; e++) begin
            if (e < 4) begin
                half_clk = 1'b1; dot_prod_en = 1'b1; shift = fr[e].sh;
                r_addr = fr[e].addr; prod = fr[e].p;
            end else begin
                half_clk = 1'b0; dot_prod_en = 1'b0;
            end
            step();
            if (e == 2) begin
                chk_result("fullrate first", 1'b1,
                           {32'd0, 32'd2, OVF_EXP, 32'd4}, 10'h021);
            end else if (e == 5) begin
                chk_result("fullrate second", 1'b1,
                           {32'd2, OVF_EXP, 32'd4, 32'd33}, 10'h024);
            end else begin
                chk($sformatf("fullrate edge%0d valid", e), 128'(dp_valid), 128'd0);
            end
            if (e == 1) chk("fullrate busy", 128'(busy), 128'd1);
            if (e == 6) chk("fullrate idle", 128'(busy), 128'd0);
            $display("fullrate edge %0d: valid=%0d lane0=%h addr=%h", e, dp_valid,
                     dp_vec[31:0], dp_addr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
